// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed scan controller for a shared 7-segment decoder
//            with guard blanking, leading-zero suppression and frame-synced
//            display updates.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lz_en,
    output logic [3:0]              dec_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    updated
);

    localparam int unsigned        c_CNT_W    = $clog2(REFRESH_DIV);
    localparam int unsigned        c_IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_SHOW_END = c_CNT_W'(REFRESH_DIV - BLANK_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_v;
    logic [3:0]              r_dec;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;
    logic                    r_updated;

    logic [3:0]              w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic                    w_zero_run;
    logic                    w_last_cnt;
    logic                    w_wrap;
    logic                    w_show;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = r_disp[4*gi +: 4];
    end

    // Blanking walks down from the most significant digit; digit 0 is never blanked.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run && (w_digit[i] == 4'd0);
            w_blank[i] = lz_en && w_zero_run;
        end
    end

    always_comb begin
        w_last_cnt = (r_cnt == c_CNT_LAST);
        w_wrap     = en && w_last_cnt && (r_idx == c_IDX_LAST);
        w_show     = (r_cnt < c_SHOW_END);
        w_an_next  = '1;
        if (en && w_show && !w_blank[r_idx]) begin
            w_an_next[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_v     <= 1'b0;
            r_dec        <= 4'd0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
            r_updated    <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_dec        <= w_digit[r_idx];
            r_frame_done <= w_wrap;
            r_updated    <= 1'b0;
            if (!en) begin
                // Scanning is idle, so a load can go straight to the display.
                r_cnt <= '0;
                r_idx <= '0;
                if (load) begin
                    r_disp    <= digits_in;
                    r_pend_v  <= 1'b0;
                    r_updated <= 1'b1;
                end
            end else begin
                if (w_last_cnt) begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                if (w_wrap && r_pend_v) begin
                    r_disp    <= r_pend;
                    r_pend_v  <= 1'b0;
                    r_updated <= 1'b1;
                end
                // A load on the commit cycle re-arms pend after the old value moved out.
                if (load) begin
                    r_pend   <= digits_in;
                    r_pend_v <= 1'b1;
                end
            end
        end
    end

    assign dec_in     = r_dec;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign updated    = r_updated;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl against a frame-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int FRAME = N * RD;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic        lz_en;
    logic [3:0]  dec_in;
    logic [3:0]  an;
    logic        frame_done;
    logic        updated;

    int total;
    int bad;

    // Reference model: position within the frame plus display/pending data.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    logic [3:0]  e_dec;
    logic [3:0]  e_an;
    logic        e_fd;
    logic        e_upd;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .lz_en     (lz_en),
        .dec_in    (dec_in),
        .an        (an),
        .frame_done(frame_done),
        .updated   (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    function automatic int top_nonzero(input logic [15:0] v);
        for (int i = N - 1; i >= 0; i--) begin
            if (digit_of(v, i) != 4'd0) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    task automatic model_step();
        int cnt;
        int idx;
        cnt   = m_t % RD;
        idx   = (m_t / RD) % N;
        e_dec = digit_of(m_disp, idx);
        e_an  = 4'hF;
        if (en && (cnt < RD - BL) && !(lz_en && (idx > top_nonzero(m_disp))))
            e_an[idx] = 1'b0;
        e_fd  = 1'b0;
        e_upd = 1'b0;
        if (!en) begin
            m_t = 0;
            if (load) begin
                m_disp = digits_in;
                m_pv   = 1'b0;
                e_upd  = 1'b1;
            end
        end else begin
            if (m_t == FRAME - 1) begin
                e_fd = 1'b1;
                if (m_pv) begin
                    m_disp = m_pend;
                    m_pv   = 1'b0;
                    e_upd  = 1'b1;
                end
            end
            if (load) begin
                m_pend = digits_in;
                m_pv   = 1'b1;
            end
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic tick(input logic e, input logic ld, input logic [15:0] d, input logic lz);
        en        = e;
        load      = ld;
        digits_in = d;
        lz_en     = lz;
        model_step();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({an, dec_in, frame_done, updated} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset got an=%b dec=%h fd=%b upd=%b want an=1111 dec=0 fd=0 upd=0",
                     an, dec_in, frame_done, updated);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int n_fd = 0;
        int n_upd = 0;
        for (int c = 0; c <= 3 * FRAME; c++) begin
            tick(c != 0, c == 1, 16'h4321, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL basic c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            n_fd  += int'(frame_done);
            n_upd += int'(updated);
        end
        total++;
        if (n_fd !== 3 || n_upd !== 1) begin
            bad++;
            $display("FAIL basic_pulses got fd=%0d upd=%0d want fd=3 upd=1", n_fd, n_upd);
        end
    endtask

    task automatic test_tearing();
        int n_upd = 0;
        for (int c = 0; c <= 2 * FRAME; c++) begin
            tick(c != 0, c == 19, 16'h7777, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL tearing c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            if (updated === 1'b1) begin
                n_upd++;
                total++;
                if (frame_done !== 1'b1) begin
                    bad++;
                    $display("FAIL tearing_sync c=%0d got fd=%b want fd=1", c, frame_done);
                end
            end
            if (c == 25) begin
                total++;
                if (dec_in !== 4'h4) begin
                    bad++;
                    $display("FAIL tearing_old c=%0d got dec=%h want dec=4", c, dec_in);
                end
            end
            if (c == 34) begin
                total++;
                if (dec_in !== 4'h7) begin
                    bad++;
                    $display("FAIL tearing_new c=%0d got dec=%h want dec=7", c, dec_in);
                end
            end
        end
        total++;
        if (n_upd !== 1) begin
            bad++;
            $display("FAIL tearing_upd got %0d want 1", n_upd);
        end
    endtask

    task automatic test_back_to_back();
        int n_upd = 0;
        logic [15:0] d;
        for (int c = 0; c <= 2 * FRAME; c++) begin
            d = (c == 6) ? 16'h1111 : 16'h2222;
            tick(c != 0, (c == 6) || (c == 7), d, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL b2b c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            n_upd += int'(updated);
            if (c == 34) begin
                total++;
                if (dec_in !== 4'h2) begin
                    bad++;
                    $display("FAIL b2b_val got dec=%h want dec=2", dec_in);
                end
            end
        end
        total++;
        if (n_upd !== 1) begin
            bad++;
            $display("FAIL b2b_upd got %0d want 1", n_upd);
        end
    endtask

    task automatic test_load_on_commit();
        int n_upd = 0;
        logic [15:0] d;
        for (int c = 0; c <= 3 * FRAME; c++) begin
            d = (c == 11) ? 16'h5555 : 16'h6666;
            tick(c != 0, (c == 11) || (c == 32), d, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL commit c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            n_upd += int'(updated);
            if (c == 34 || c == 66) begin
                total++;
                if (dec_in !== ((c == 34) ? 4'h5 : 4'h6)) begin
                    bad++;
                    $display("FAIL commit_val c=%0d got dec=%h want dec=%h",
                             c, dec_in, (c == 34) ? 4'h5 : 4'h6);
                end
            end
        end
        total++;
        if (n_upd !== 2) begin
            bad++;
            $display("FAIL commit_upd got %0d want 2", n_upd);
        end
    endtask

    task automatic test_lz();
        int low_a [4] = '{0, 0, 0, 0};
        int low_b [4] = '{0, 0, 0, 0};
        logic [15:0] d;
        for (int c = 0; c <= 2 * FRAME + 1; c++) begin
            d = (c == 0) ? 16'h0050 : 16'h0000;
            tick((c != 0) && (c != FRAME + 1), (c == 0) || (c == FRAME + 1), d, 1'b1);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL lz c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            for (int i = 0; i < N; i++) begin
                if (c >= 1 && c <= FRAME && an[i] === 1'b0) low_a[i]++;
                if (c >= FRAME + 2 && an[i] === 1'b0) low_b[i]++;
            end
        end
        total++;
        if (low_a[3] !== 0 || low_a[2] !== 0 || low_a[1] !== RD - BL || low_a[0] !== RD - BL) begin
            bad++;
            $display("FAIL lz_0050 got lows=%0d,%0d,%0d,%0d want 0,0,6,6",
                     low_a[3], low_a[2], low_a[1], low_a[0]);
        end
        total++;
        if (low_b[3] !== 0 || low_b[2] !== 0 || low_b[1] !== 0 || low_b[0] !== RD - BL) begin
            bad++;
            $display("FAIL lz_0000 got lows=%0d,%0d,%0d,%0d want 0,0,0,6",
                     low_b[3], low_b[2], low_b[1], low_b[0]);
        end
    endtask

    task automatic test_disable();
        logic e;
        for (int c = 0; c <= 24; c++) begin
            e = (c != 0) && !(c >= 12 && c <= 14);
            tick(e, c == 13, 16'h0123, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL disable c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            if (c == 12) begin
                total++;
                if (an !== 4'hF) begin
                    bad++;
                    $display("FAIL disable_an got an=%b want an=1111", an);
                end
            end
            if (c == 13) begin
                total++;
                if (updated !== 1'b1) begin
                    bad++;
                    $display("FAIL disable_load got upd=%b want upd=1", updated);
                end
            end
            if (c == 15) begin
                total++;
                if (an !== 4'b1110 || dec_in !== 4'h3) begin
                    bad++;
                    $display("FAIL disable_restart got an=%b dec=%h want an=1110 dec=3", an, dec_in);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n_upd = 0;
        logic [15:0] d;
        for (int c = 0; c <= 12; c++) begin
            d = (c == 0) ? 16'h0123 : 16'h9999;
            tick(c != 0, (c == 0) || (c == 4), d, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL areset_pre c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({an, dec_in, frame_done, updated} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL areset_async got an=%b dec=%h fd=%b upd=%b want an=1111 dec=0 fd=0 upd=0",
                     an, dec_in, frame_done, updated);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick(1'b1, 1'b0, 16'h0000, 1'b0);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL areset_post c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
            n_upd += int'(updated);
        end
        total++;
        if (n_upd !== 0) begin
            bad++;
            $display("FAIL areset_discard got upd=%0d want 0", n_upd);
        end
    endtask

    task automatic test_random();
        logic        e;
        logic        ld;
        logic        lz;
        logic [15:0] d;
        lz = 1'b0;
        for (int c = 0; c < 800; c++) begin
            e  = ($urandom_range(0, 19) != 0);
            ld = ($urandom_range(0, 15) == 0);
            d  = 16'($urandom);
            d  = d >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 63) == 0) lz = ~lz;
            tick(e, ld, d, lz);
            total++;
            if ({an, dec_in, frame_done, updated} !== {e_an, e_dec, e_fd, e_upd}) begin
                bad++;
                $display("FAIL random c=%0d got an=%b dec=%h fd=%b upd=%b want an=%b dec=%h fd=%b upd=%b",
                         c, an, dec_in, frame_done, updated, e_an, e_dec, e_fd, e_upd);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_basic();
        test_tearing();
        test_back_to_back();
        test_load_on_commit();
        test_lz();
        test_disable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the shared 4-bit-code to 7-segment decoder on the board display.
- Holds NUM_DIGITS 4-bit digit codes and drives one code at a time onto the decoder input, together with the matching active-low anode.
- Adds a dark guard interval between digits to prevent ghosting.
- Applies new display data only at frame boundaries, so no tearing.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 2000: cycles at the end of each slot with all anodes off; must be at least 1.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: scan enable.
- load, in, 1: single-cycle strobe; captures digits_in.
- digits_in, in, 4*NUM_DIGITS: digit codes; bits [3:0] are digit 0 (least significant).
- lz_en, in, 1: leading-zero blanking enable.
- dec_in, out, 4: code to the shared decoder input.
- an, out, NUM_DIGITS: anodes, active-low.
- frame_done, out, 1: one-cycle pulse when the index wraps to 0.
- updated, out, 1: one-cycle pulse when pending data is committed to the display.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: cnt=0, idx=0, disp=0, pend=0, pend_v=0, dec_in=0, an=all 1, frame_done=0, updated=0.
- Counter: cnt runs 0..REFRESH_DIV-1 while en=1.
  - At cnt=REFRESH_DIV-1: cnt goes to 0 and idx goes to idx+1.
  - idx wraps from NUM_DIGITS-1 to 0.
- Slot phases (state is derived from cnt):
  - SHOW: cnt < REFRESH_DIV-BLANK_CYCLES.
  - GUARD: all remaining cycles of the slot.
- Outputs are registered, 1-cycle latency: an and dec_in at edge t+1 reflect idx, cnt and disp at cycle t.
  - dec_in = disp[idx] in both phases.
  - an[idx]=0 only in SHOW and only if digit idx is not blanked. All other an bits are 1.
- Wrap and commit: on the cycle idx wraps to 0, frame_done pulses.
  - If pend_v=1 on that cycle: disp<=pend, pend_v<=0, updated pulses in the same cycle.
- Load handshake:
  - load=1 sets pend<=digits_in and pend_v<=1. No backpressure; last load wins.
  - load coincident with a commit: the old pend is committed, the new data goes to pend, and pend_v stays 1.
  - load while en=0: disp<=digits_in directly, updated pulses next edge, pend_v<=0.
- Leading-zero blanking (lz_en=1):
  - Digit i>0 is blanked iff disp[i] and every more-significant digit equal 0.
  - Digit 0 is never blanked.
  - Evaluated on disp, never on pend.
- Codes: 0..15 pass unmodified. Out-of-range handling belongs to the decoder; the controller does not filter codes.
- en=0: cnt<=0 and idx<=0; an=all 1 from the next edge; frame_done stays 0. Restarting with en=1 begins at digit 0, SHOW.
- Asynchronous reset mid-frame or mid-slot: immediate return to reset values, pending load discarded. After release, scan restarts at digit 0 if en=1.
- Widths: cnt is clog2(REFRESH_DIV) bits; idx is clog2(NUM_DIGITS) bits. No overflow beyond the wrap points.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, en=1, load digits_in=16'h4321 then wait one frame -> next frame: dec_in sequence 1,2,3,4; an 1110, 1101, 1011, 0111, each low for 6 cycles then 1111 for 2 cycles; frame_done pulse every 32 cycles.
- Tearing: load 16'h7777 while idx=2 -> digits 2 and 3 keep old values; updated and frame_done pulse on the same cycle at wrap; the following frame shows 7,7,7,7.
- Back-to-back: load 16'h1111 then 16'h2222 in consecutive cycles mid-frame -> only 2,2,2,2 displayed; a single updated pulse.
- Load on commit cycle: pend=16'h5555 and a new load of 16'h6666 on the wrap cycle -> a frame of 5555, then 6666 committed at the next wrap.
- lz_en=1, disp=16'h0050 -> an never low for digits 3 and 2; digits 1 and 0 are shown. disp=16'h0000 -> only digit 0 is shown.
- Disable and reset: drop en mid-slot -> an=1111 next edge; load 16'h0123 while disabled -> updated next edge; re-enable -> scan from digit 0 showing 3. Assert rst_n low mid-slot -> an=1111 and dec_in=0 immediately, without waiting for clk.
